osd_fade_ctrl: RTL and testbench

OSD_FADE_CTRL -- requirements
Module: osd_fade_ctrl

---
 rtl/osd_ctrl_pkg.sv | 16 +
 rtl/osd_fade_ctrl_if.sv | 9 +
 rtl/frame_tick_det.sv | 17 +
 rtl/osd_fade_ctrl.sv | 133 +++++++++++++
 tb/tb_osd_fade_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/osd_ctrl_pkg.sv
// Shared definitions for the OSD fade controller: FSM states, register map and
// config register reset values.
package osd_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StFadeIn, StHold, StFadeOut} state_e;

  localparam logic [1:0] AddrCtrl       = 2'd0;
  localparam logic [1:0] AddrFadeStep   = 2'd1;
  localparam logic [1:0] AddrHoldFrames = 2'd2;
  localparam logic [1:0] AddrScrollStep = 2'd3;

  localparam logic [8:0]  FadeStepRst   = 9'd8;
  localparam logic [15:0] HoldFramesRst = 16'd300;
  localparam logic [7:0]  ScrollStepRst = 8'd1;

endpackage

// File: rtl/osd_fade_ctrl_if.sv
// Configuration write bus of the OSD fade controller.
interface osd_fade_ctrl_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata);
endinterface

// File: rtl/frame_tick_det.sv
// Rising-edge detector on the frame sync; tick is combinational in the
// cycle where vsync is high and its delayed copy is still low.
module frame_tick_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic tick
);
  logic vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign tick = vsync & ~vsync_q;
endmodule

// File: rtl/osd_fade_ctrl.sv
// OSD fade controller: frame-paced alpha fade in/hold/fade out sequencer with
// a wrapping text scroll offset and shadowed configuration registers.
module osd_fade_ctrl
  import osd_ctrl_pkg::*;
#(
  parameter int unsigned SCROLL_WRAP = 1424,
  parameter int unsigned ALPHA_MAX   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lcd_vsync,
  osd_fade_ctrl_if.slave        cfg,
  output logic [8:0]            alpha_data,
  output logic [10:0]           shift_data,
  output logic                  osd_en,
  output logic                  busy
);
  localparam logic [9:0]  AlphaMax   = 10'(ALPHA_MAX);
  localparam logic [11:0] ScrollWrap = 12'(SCROLL_WRAP);

  logic tick;

  frame_tick_det u_tick_det (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (lcd_vsync),
    .tick  (tick)
  );

  state_e      state_q, state_d;
  logic [9:0]  alpha_q, alpha_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [10:0] shift_q, shift_d;

  logic [8:0]  fade_step_sh_q, fade_step_q;
  logic [15:0] hold_frames_sh_q, hold_frames_q;
  logic [7:0]  scroll_step_sh_q, scroll_step_q;

  logic        ctrl_wr, start, stop;
  logic [9:0]  step_eff, alpha_dec, alpha_inc_raw, alpha_inc;
  logic [11:0] shift_sum;

  assign ctrl_wr = cfg.cfg_we && (cfg.cfg_addr == AddrCtrl);
  assign start   = ctrl_wr && cfg.cfg_wdata[0];
  assign stop    = ctrl_wr && cfg.cfg_wdata[1];

  // Zero step would stall a fade forever, so it behaves as one.
  assign step_eff      = (fade_step_q == '0) ? 10'd1 : {1'b0, fade_step_q};
  assign alpha_dec     = (alpha_q > step_eff) ? (alpha_q - step_eff) : '0;
  assign alpha_inc_raw = alpha_q + step_eff;
  assign alpha_inc     = (alpha_inc_raw >= AlphaMax) ? AlphaMax : alpha_inc_raw;
  assign shift_sum     = {1'b0, shift_q} + {4'b0, scroll_step_q};

  always_comb begin
    state_d    = state_q;
    alpha_d    = alpha_q;
    hold_cnt_d = hold_cnt_q;
    shift_d    = shift_q;

    if (tick) begin
      if (state_q != StIdle) begin
        shift_d = 11'((shift_sum >= ScrollWrap) ? (shift_sum - ScrollWrap) : shift_sum);
      end
      case (state_q)
        StFadeIn: begin
          alpha_d = alpha_dec;
          if (alpha_dec == '0) begin
            hold_cnt_d = hold_frames_q;
            state_d    = StHold;
          end
        end
        StHold: begin
          if (hold_cnt_q == '0) state_d = StFadeOut;
          else                  hold_cnt_d = hold_cnt_q - 16'd1;
        end
        StFadeOut: begin
          alpha_d = alpha_inc;
          if (alpha_inc == AlphaMax) state_d = StIdle;
        end
        default: ;
      endcase
    end

    // Control writes override the tick-driven transition; stop wins over start.
    if (stop) begin
      if (state_q == StFadeIn || state_q == StHold) state_d = StFadeOut;
    end else if (start && state_q == StIdle) begin
      alpha_d = AlphaMax;
      state_d = StFadeIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alpha_q    <= AlphaMax;
      hold_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      alpha_q    <= alpha_d;
      hold_cnt_q <= hold_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Writes land in shadows; active copies only move on a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_step_sh_q   <= FadeStepRst;
      hold_frames_sh_q <= HoldFramesRst;
      scroll_step_sh_q <= ScrollStepRst;
      fade_step_q      <= FadeStepRst;
      hold_frames_q    <= HoldFramesRst;
      scroll_step_q    <= ScrollStepRst;
    end else begin
      if (tick) begin
        fade_step_q   <= fade_step_sh_q;
        hold_frames_q <= hold_frames_sh_q;
        scroll_step_q <= scroll_step_sh_q;
      end
      if (cfg.cfg_we && cfg.cfg_addr == AddrFadeStep)   fade_step_sh_q   <= cfg.cfg_wdata[8:0];
      if (cfg.cfg_we && cfg.cfg_addr == AddrHoldFrames) hold_frames_sh_q <= cfg.cfg_wdata;
      if (cfg.cfg_we && cfg.cfg_addr == AddrScrollStep) scroll_step_sh_q <= cfg.cfg_wdata[7:0];
    end
  end

  assign alpha_data = alpha_q[8:0];
  assign shift_data = shift_q;
  assign osd_en     = (state_q != StIdle);
  assign busy       = (state_q == StFadeIn) || (state_q == StFadeOut);

endmodule

// File: tb/tb_osd_fade_ctrl.sv
// Bench for osd_fade_ctrl: frame-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_osd_fade_ctrl;
  localparam int Wrap = 1424;
  localparam int AMax = 256;
  localparam int MIdle = 0, MIn = 1, MHold = 2, MOut = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_vsync = 1'b0;
  logic [8:0]  alpha_data;
  logic [10:0] shift_data;
  logic        osd_en, busy;

  osd_fade_ctrl_if cfg_bus ();

  osd_fade_ctrl #(.SCROLL_WRAP(Wrap), .ALPHA_MAX(AMax)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_vsync  (lcd_vsync),
    .cfg        (cfg_bus),
    .alpha_data (alpha_data),
    .shift_data (shift_data),
    .osd_en     (osd_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per clock edge, frame-level rules in plain ints.
  int m_mode, m_alpha, m_hold, m_shift, m_vs;
  int sh_step, act_step, sh_hold, act_hold, sh_scroll, act_scroll;

  task automatic model_reset();
    m_mode = MIdle; m_alpha = AMax; m_hold = 0; m_shift = 0; m_vs = 0;
    sh_step = 8; act_step = 8; sh_hold = 300; act_hold = 300; sh_scroll = 1; act_scroll = 1;
  endtask

  task automatic model_step();
    bit tk, st, sp, we;
    int step, na, nm, nh, ns;
    tk = lcd_vsync && (m_vs == 0);
    m_vs = int'(lcd_vsync);
    we = cfg_bus.cfg_we;
    st = we && cfg_bus.cfg_addr == 2'd0 && cfg_bus.cfg_wdata[0];
    sp = we && cfg_bus.cfg_addr == 2'd0 && cfg_bus.cfg_wdata[1];
    step = (act_step == 0) ? 1 : act_step;
    na = m_alpha; nm = m_mode; nh = m_hold; ns = m_shift;
    if (tk) begin
      if (m_mode != MIdle) ns = (m_shift + act_scroll) % Wrap;
      if (m_mode == MIn) begin
        na = (m_alpha - step < 0) ? 0 : m_alpha - step;
        if (na == 0) begin nm = MHold; nh = act_hold; end
      end else if (m_mode == MHold) begin
        if (m_hold == 0) nm = MOut; else nh = m_hold - 1;
      end else if (m_mode == MOut) begin
        na = (m_alpha + step > AMax) ? AMax : m_alpha + step;
        if (na == AMax) nm = MIdle;
      end
    end
    if (sp) begin
      if (m_mode == MIn || m_mode == MHold) nm = MOut;
    end else if (st && m_mode == MIdle) begin
      nm = MIn; na = AMax;
    end
    m_alpha = na; m_mode = nm; m_hold = nh; m_shift = ns;
    if (tk) begin act_step = sh_step; act_hold = sh_hold; act_scroll = sh_scroll; end
    if (we && cfg_bus.cfg_addr == 2'd1) sh_step = int'(cfg_bus.cfg_wdata[8:0]);
    if (we && cfg_bus.cfg_addr == 2'd2) sh_hold = int'(cfg_bus.cfg_wdata);
    if (we && cfg_bus.cfg_addr == 2'd3) sh_scroll = int'(cfg_bus.cfg_wdata[7:0]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      if (rst_n) begin
        check("model_alpha", int'(alpha_data), m_alpha);
        check("model_shift", int'(shift_data), m_shift);
        check("model_osd_en", int'(osd_en), int'(m_mode != MIdle));
        check("model_busy", int'(busy), int'(m_mode == MIn || m_mode == MOut));
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_wdata = d;
    @(negedge clk);
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic frame_tick();
    @(negedge clk) lcd_vsync = 1'b1;
    @(negedge clk) lcd_vsync = 1'b0;
    @(negedge clk);
  endtask

  int fin_exp[4] = '{192, 128, 64, 0};
  int fout_exp[3] = '{100, 200, 256};

  initial begin
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_wdata = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_alpha", int'(alpha_data), 256);
    check("rst_shift", int'(shift_data), 0);
    check("rst_osd_en", int'(osd_en), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // Fade in at step 64, hold 2 frames, fade out at step 100.
    wr(2'd1, 16'd64); wr(2'd2, 16'd2); frame_tick();
    wr(2'd0, 16'd1);
    check("start_busy", int'(busy), 1);
    check("start_alpha", int'(alpha_data), 256);
    for (int i = 0; i < 4; i++) begin
      frame_tick();
      check("fade_in_alpha", int'(alpha_data), fin_exp[i]);
    end
    check("hold_busy", int'(busy), 0);
    check("hold_osd_en", int'(osd_en), 1);
    wr(2'd1, 16'd100);
    frame_tick(); check("hold1_busy", int'(busy), 0);
    frame_tick(); check("hold2_busy", int'(busy), 0);
    frame_tick(); check("hold3_busy", int'(busy), 1);
    check("hold3_alpha", int'(alpha_data), 0);
    for (int i = 0; i < 3; i++) begin
      frame_tick();
      check("fade_out_alpha", int'(alpha_data), fout_exp[i]);
    end
    check("done_osd_en", int'(osd_en), 0);

    // Early stop during fade-in.
    wr(2'd1, 16'd64); frame_tick();
    wr(2'd0, 16'd1);
    frame_tick(); frame_tick();
    check("early_alpha", int'(alpha_data), 128);
    wr(2'd0, 16'd2);
    check("stop_busy", int'(busy), 1);
    check("stop_alpha", int'(alpha_data), 128);
    frame_tick(); check("early_out1", int'(alpha_data), 192);
    check("early_out1_en", int'(osd_en), 1);
    frame_tick(); check("early_out2", int'(alpha_data), 256);
    check("early_idle_en", int'(osd_en), 0);

    // Start and stop together from idle.
    wr(2'd0, 16'd3);
    repeat (2) @(negedge clk);
    check("both_osd_en", int'(osd_en), 0);
    check("both_alpha", int'(alpha_data), 256);

    // Zero hold, then async reset in fade-out at alpha 64.
    wr(2'd2, 16'd0); wr(2'd1, 16'd64); frame_tick();
    wr(2'd0, 16'd1);
    repeat (4) frame_tick();
    check("h0_alpha", int'(alpha_data), 0);
    check("h0_busy", int'(busy), 0);
    frame_tick(); check("h0_out_busy", int'(busy), 1);
    frame_tick(); check("h0_out_alpha", int'(alpha_data), 64);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_alpha", int'(alpha_data), 256);
    check("arst_shift", int'(shift_data), 0);
    check("arst_osd_en", int'(osd_en), 0);
    check("arst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Scroll wrap with fade_step 0 acting as 1; start+stop mid-fade acts as stop.
    wr(2'd3, 16'd200); wr(2'd1, 16'd0); frame_tick();
    wr(2'd0, 16'd1);
    repeat (7) frame_tick();
    check("scroll_pre", int'(shift_data), 1400);
    check("step0_alpha", int'(alpha_data), 249);
    frame_tick();
    check("scroll_wrap", int'(shift_data), 176);
    wr(2'd0, 16'd3);
    check("ss_busy", int'(busy), 1);
    check("ss_alpha", int'(alpha_data), 248);
    frame_tick();
    check("ss_out_alpha", int'(alpha_data), 249);
    check("ss_shift", int'(shift_data), 376);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
